pc_unit: RTL and testbench

- Parametrised program-counter unit; successor to the single-register PC used by the MIPS_32 fetch stage.
- Holds the fetch index and selects the next one from: sequential increment, stall hold, branch/jump redirect, exception vector, or an optional return-address stack (RAS).
- Adds a boot/run/halt state machine and a fetch-valid qualifier.
- Sits between the branch/exception control logic and the instruction memory address port.

---
 rtl/pc_unit.sv | 185 ++++++++++++++++++
 tb/tb_pc_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage.
// Holds the fetch index and picks the next one from: exception vector,
// branch/jump redirect, return-address stack, stall hold, or pc+INCR.
// A BOOT/RUN/HALT state machine qualifies fetches via fetch_valid.
// State updates happen on the falling clock edge to match the fetch datapath.
// Optional feature: define PC_RAS_EN to build the return-address stack;
// without it ras_push/ras_pop are ignored, ras_empty=1 and ras_overflow=0.
module pc_unit #(
    parameter int                 WIDTH        = 32,
    parameter int                 INCR         = 4,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0]   EXC_VECTOR   = 32'h0000_0180,
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             exc,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             ras_push,
    input  logic             ras_pop,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             fetch_valid,
    output logic             halted,
    output logic             ras_empty,
    output logic             ras_overflow
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             halted_q, halted_d;

    // Interface between the next-PC selector and the stack.
    logic             ras_active;  // a RUN edge on which the stack may change
    logic             pop_hit;     // a pop that actually removes an entry
    logic [WIDTH-1:0] ras_top;

    // Sequential successor; wraps modulo 2^WIDTH.
    assign pc_plus = pc_q + WIDTH'(INCR);

    // Stack moves only on RUN edges that are not exceptions, halts or stalls.
    assign ras_active = (state_q == ST_RUN) && !exc && !halt && !stall;

    assign pc          = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign halted      = halted_q;

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    // Circular buffer: ptr_q indexes the newest entry, cnt_q counts live
    // entries. When full, the slot after the newest is the oldest, so a push
    // naturally overwrites it.
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_up;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             do_push, do_pop;

    assign ptr_up       = ptr_q + PTR_W'(1);
    assign ras_top      = ras_q[ptr_q];
    assign do_push      = ras_active && ras_push;
    assign do_pop       = ras_active && ras_pop && (cnt_q != '0);
    assign pop_hit      = do_pop;
    assign ras_empty    = (cnt_q == '0);
    assign ras_overflow = ovf_q;

    // Stack next-state: push, pop, or replace-top when both arrive together.
    always_comb begin
        ras_d = ras_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (do_push && do_pop) begin
            ras_d[ptr_q] = pc_plus;
        end else if (do_push) begin
            ptr_d         = ptr_up;
            ras_d[ptr_up] = pc_plus;
            if (cnt_q == CNT_W'(RAS_DEPTH)) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (do_pop) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Stack registers; overflow is sticky until reset.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ras_q <= ras_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
`else
    logic unused_ras;

    assign ras_top      = '0;
    assign pop_hit      = 1'b0;
    assign ras_empty    = 1'b1;
    assign ras_overflow = 1'b0;
    assign unused_ras   = ras_push ^ ras_pop ^ ras_active ^ (RAS_DEPTH == 0);
`endif

    // Next state and next PC; exception beats halt, halt beats redirects.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                pc_d    = RESET_VECTOR;
            end
            ST_RUN: begin
                if (exc) begin
                    pc_d = EXC_VECTOR;
                end else if (halt) begin
                    state_d = ST_HALT;
                end else if (redirect) begin
                    pc_d = redirect_target;
                end else if (pop_hit) begin
                    pc_d = ras_top;
                end else if (stall) begin
                    pc_d = pc_q;
                end else begin
                    pc_d = pc_plus;
                end
            end
            ST_HALT: begin
                if (exc) begin
                    state_d = ST_RUN;
                    pc_d    = EXC_VECTOR;
                end else if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
                pc_d    = RESET_VECTOR;
            end
        endcase
        fetch_valid_d = (state_d == ST_RUN);
        halted_d      = (state_d == ST_HALT);
    end

    // PC and state registers.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            halted_q      <= halted_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vectors, a queue-based reference
// model compared every cycle, and hand-computed literal checks.
module tb_pc_unit;

  localparam int RAS_DEPTH = 4;
`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stall, halt, resume, exc, redirect, ras_push, ras_pop;
  logic [31:0] redirect_target;
  logic [31:0] pc, pc_plus;
  logic        fetch_valid, halted, ras_empty, ras_overflow;

  int n_total = 0;
  int n_pass  = 0;

  pc_unit #(
    .WIDTH(32), .INCR(4), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h180),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt), .resume(resume),
    .exc(exc), .redirect(redirect), .redirect_target(redirect_target),
    .ras_push(ras_push), .ras_pop(ras_pop), .pc(pc), .pc_plus(pc_plus),
    .fetch_valid(fetch_valid), .halted(halted), .ras_empty(ras_empty),
    .ras_overflow(ras_overflow)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // mode: 0 = boot, 1 = run, 2 = halt
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];
  bit          m_ovf;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0;
      m_pc   = 32'h0;
      m_stack.delete();
      m_ovf  = 1'b0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: begin
          if (exc) m_pc = 32'h180;
          else if (halt) m_mode = 2;
          else begin
            logic [31:0] nxt, plus, top;
            bit can_pop;
            plus    = m_pc + 32'd4;
            nxt     = plus;
            can_pop = RAS_EN && ras_pop && !stall && (m_stack.size() > 0);
            top     = can_pop ? m_stack[$] : 32'h0;
            if (redirect) nxt = redirect_target;
            else if (can_pop) nxt = top;
            else if (stall) nxt = m_pc;
            if (RAS_EN && !stall) begin
              if (can_pop) void'(m_stack.pop_back());
              if (ras_push) begin
                if (m_stack.size() == RAS_DEPTH) begin
                  m_stack.delete(0);
                  m_ovf = 1'b1;
                end
                m_stack.push_back(plus);
              end
            end
            m_pc = nxt;
          end
        end
        default: begin
          if (exc) begin m_mode = 1; m_pc = 32'h180; end
          else if (resume) m_mode = 1;
        end
      endcase
    end
  end

  // Compare process: outputs are stable at the rising edge.
  always @(posedge clk) begin
    if (!rst) begin
      check("pc", pc, m_pc);
      check("pc_plus", pc_plus, m_pc + 32'd4);
      check("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_mode == 1});
      check("halted", {31'b0, halted}, {31'b0, m_mode == 2});
      check("ras_empty", {31'b0, ras_empty}, {31'b0, m_stack.size() == 0});
      check("ras_overflow", {31'b0, ras_overflow}, {31'b0, m_ovf});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [31:0] t);
    redirect = 1'b1;
    redirect_target = t;
    cyc();
    redirect = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b0;
    {stall, halt, resume, exc, redirect, ras_push, ras_pop} = '0;
    redirect_target = '0;
    #1 rst = 1'b1;
    cyc();
    cyc();
    check("rst_pc", pc, 32'h0);
    check("rst_fv", {31'b0, fetch_valid}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_ras_empty", {31'b0, ras_empty}, 32'h1);
    check("rst_ovf", {31'b0, ras_overflow}, 32'h0);
    rst = 1'b0;
    cyc();
    check("boot_fv", {31'b0, fetch_valid}, 32'h1);
    check("boot_pc", pc, 32'h0);
    cyc();
    check("first_inc", pc, 32'h4);

    // Priority
    go(32'h100);
    check("prio_setup", pc, 32'h100);
    exc = 1'b1; redirect = 1'b1; redirect_target = 32'h200; stall = 1'b1;
    cyc();
    exc = 1'b0; redirect = 1'b0; stall = 1'b0;
    check("prio_exc", pc, 32'h180);
    go(32'h100);
    redirect = 1'b1; redirect_target = 32'h200; stall = 1'b1;
    cyc();
    redirect = 1'b0;
    check("prio_redirect", pc, 32'h200);
    go(32'h100);
    stall = 1'b1;
    cyc();
    check("prio_stall1", pc, 32'h100);
    cyc();
    check("prio_stall2", pc, 32'h100);
    stall = 1'b0;

    // Wrap
    go(32'hFFFF_FFFC);
    check("wrap_plus", pc_plus, 32'h0);
    cyc();
    check("wrap_pc", pc, 32'h0);

    // Halt / resume
    go(32'h20);
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("halt_pc", pc, 32'h20);
      check("halt_flag", {31'b0, halted}, 32'h1);
      check("halt_fv", {31'b0, fetch_valid}, 32'h0);
      if (i < 4) cyc();
    end
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    check("resume_pc", pc, 32'h20);
    check("resume_fv", {31'b0, fetch_valid}, 32'h1);
    cyc();
    check("resume_inc", pc, 32'h24);
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    check("halt2_flag", {31'b0, halted}, 32'h1);
    exc = 1'b1; resume = 1'b1;
    cyc();
    exc = 1'b0; resume = 1'b0;
    check("halt_exc_pc", pc, 32'h180);
    check("halt_exc_flag", {31'b0, halted}, 32'h0);

`ifdef PC_RAS_EN
    go(32'h10);
    ras_push = 1'b1;
    cyc();
    ras_push = 1'b0;
    check("ras_push1", pc, 32'h14);
    go(32'h50);
    ras_push = 1'b1;
    cyc();
    ras_push = 1'b0;
    ras_pop = 1'b1;
    cyc();
    check("ras_pop1", pc, 32'h54);
    cyc();
    check("ras_pop2", pc, 32'h14);
    check("ras_empty_after", {31'b0, ras_empty}, 32'h1);
    cyc();
    check("ras_pop3", pc, 32'h18);
    check("ras_empty_pop3", {31'b0, ras_empty}, 32'h1);
    ras_pop = 1'b0;
    go(32'h100);
    ras_push = 1'b1;
    for (int i = 2; i <= 6; i++) begin
      redirect = 1'b1;
      redirect_target = 32'(i) << 8;
      cyc();
    end
    ras_push = 1'b0;
    redirect = 1'b0;
    check("ovf_set", {31'b0, ras_overflow}, 32'h1);
    ras_pop = 1'b1;
    cyc();
    check("ovf_pop1", pc, 32'h504);
    cyc();
    check("ovf_pop2", pc, 32'h404);
    cyc();
    check("ovf_pop3", pc, 32'h304);
    cyc();
    check("ovf_pop4", pc, 32'h204);
    check("ovf_empty", {31'b0, ras_empty}, 32'h1);
    check("ovf_sticky", {31'b0, ras_overflow}, 32'h1);
    ras_pop = 1'b0;
`else
    go(32'h10);
    ras_push = 1'b1;
    cyc();
    ras_push = 1'b0;
    check("noras_push", pc, 32'h14);
    check("noras_empty1", {31'b0, ras_empty}, 32'h1);
    ras_pop = 1'b1;
    cyc();
    ras_pop = 1'b0;
    check("noras_pop", pc, 32'h18);
    check("noras_empty2", {31'b0, ras_empty}, 32'h1);
`endif

    // Reset mid-run
    go(32'h40);
    check("mid_setup", pc, 32'h40);
    rst = 1'b1;
    #1;
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_fv", {31'b0, fetch_valid}, 32'h0);
    check("mid_rst_ovf", {31'b0, ras_overflow}, 32'h0);
    check("mid_rst_empty", {31'b0, ras_empty}, 32'h1);
    cyc();
    rst = 1'b0;
    cyc();
    check("mid_boot_fv", {31'b0, fetch_valid}, 32'h1);
    check("mid_boot_pc", pc, 32'h0);
    cyc();
    check("mid_inc", pc, 32'h4);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
